multi_channel_framer: RTL
=========================

# multi_channel_framer

Parametrised UART frame generator serving NCH independent data sources. Each channel has a one-entry holding register with a valid/ready handshake. A round-robin arbiter picks the next pending channel and serialises its NBYTES payload into a byte stream for the UART TX FIFO: start byte, channel ID, payload LSB-first, 8-bit checksum, end byte. It sits between the sample/packet producers and the UART TX FIFO, and it honours FIFO-full backpressure on every byte.

## Interface
- NBYTES, 4: payload bytes per frame; ≥1.
- NCH, 2: number of input channels; 1..256.
- START_BYTE, 8'hAA: first byte of every frame.
- END_BYTE, 8'hBB: last byte of every frame.

- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- data_i  in  NCH*8*NBYTES  channel c payload at [c*8*NBYTES +: 8*NBYTES].
- valid_i  in  NCH  per-channel payload valid.
- ready_o  out  NCH  per-channel holding slot empty; transfer on valid_i[c] & ready_o[c].
- uart_fifo_full_i  in  1  TX FIFO full; no write may occur while high.
- uart_data_o  out  8  byte presented to the FIFO.
- uart_wr_en_o  out  1  FIFO write strobe.
- busy_o  out  1  high whenever state != IDLE.

## Operation
- Frame format, NBYTES+4 bytes: START_BYTE, CH (channel index, zero-extended to 8 bits), payload byte 0..NBYTES-1 (bits [7:0] first), CSUM, END_BYTE.
- CSUM is the sum modulo 256 of CH and all payload bytes. Carries are discarded.
- Holding slots:
  - Handshake on valid_i[c] & ready_o[c] stores data_i slice c and sets pending[c].
  - ready_o[c] = !pending[c], forced 0 while rst is high.
  - valid_i[c] with ready_o[c] low is ignored and the held data is unchanged.
- Arbitration:
  - Takes place in IDLE with any pending bit set.
  - The search starts at the rr pointer and proceeds upward mod NCH; the first pending channel g wins.
  - On grant, in one edge: shift register <= slot g, chan <= g, csum <= g, pending[g] <= 0, rr pointer <= (g+1) mod NCH, state <= WR_START.
- State machine, states IDLE, WR_START, WR_CH, WR_BYTES, WR_CSUM, WR_END:
  - IDLE → WR_START on grant, else stay.
  - WR_START → WR_CH, WR_CH → WR_BYTES, WR_CSUM → WR_END, WR_END → IDLE; each advances only when !uart_fifo_full_i.
  - WR_BYTES: on each accepted write, shift the register right 8, add the byte to csum, and increment byte_count. Exit to WR_CSUM when byte_count == NBYTES-1 and !uart_fifo_full_i. byte_count clears on leaving WR_BYTES.
  - Any undefined state → IDLE.
- Output muxing:
  - uart_data_o is combinational from state: START_BYTE, chan, shreg[7:0], csum, END_BYTE. It shows shreg[7:0] in IDLE.
  - uart_wr_en_o = (state != IDLE) & !uart_fifo_full_i.
- Widths:
  - byte_count is max(1, $clog2(NBYTES)) bits.
  - chan and the rr pointer are max(1, $clog2(NCH)) bits.

## Timing
- Reset values:
  - state IDLE; pending, rr pointer, chan, csum, byte_count and shreg all 0.
  - Outputs: uart_wr_en_o 0, busy_o 0, uart_data_o 0, ready_o 0 during reset, all-ones after release.
- Latency:
  - Handshake at edge t → pending at t.
  - Grant at edge t+1 → START_BYTE written at edge t+2 if the FIFO is not full.
- Throughput: with no backpressure, wr_en is high for NBYTES+4 consecutive cycles, followed by one mandatory IDLE cycle. Minimum frame period is NBYTES+5 cycles.
- While the FIFO is full: state, data, csum and byte_count all hold, and uart_data_o is stable.
- A channel may be reloaded while its own previous frame is transmitting, because its slot cleared at grant.
- Asserting rst mid-frame:
  - wr_en drops immediately and the frame is abandoned with no END_BYTE.
  - Pending data is discarded.

## Structure
- framer_pkg: the states_t enum, plus default START_BYTE/END_BYTE constants shared with the RX deframer.
- Sub-module rr_arbiter #(N):
  - Inputs: req, advance.
  - Outputs: grant index, any_req.
  - Owns the rr pointer.
- Top level owns the holding slots, the FSM, the shift register and the checksum.

## Test plan
- NBYTES=4, NCH=2, ch0 data 32'h44332211, full low → bytes AA 00 11 22 33 44 AA BB on 8 consecutive wr_en cycles; busy_o drops after BB.
- ch0 = 32'h44332211 and ch1 = 32'h01010101 loaded on the same cycle → ch0 frame first, one IDLE cycle, then AA 01 01 01 01 01 05 BB; the next simultaneous pair is served ch0 first again (pointer wrapped).
- Full high for 3 cycles while byte 0x22 is presented → wr_en low for those 3 cycles, uart_data_o held at 22, final stream identical to test 1.
- ch1 data 32'hFFFFFFFF → CSUM FD (1+4×FF mod 256).
- ch0 reloaded during its own frame → ready_o[0] high, second frame follows; a third valid while pending → ready_o[0] low, data ignored, second payload transmitted intact.
- rst pulsed during WR_BYTES → wr_en 0 in the same cycle, no BB emitted, ready_o 0 during reset and all-ones after; a new load produces a clean frame starting with AA.

Source files
------------

// File: rtl/framer_pkg.sv
// Shared framing definitions: FSM state encoding and default frame delimiters
// (also used by the RX deframer).
package framer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_START = 3'd1,
    WR_CH    = 3'd2,
    WR_BYTES = 3'd3,
    WR_CSUM  = 3'd4,
    WR_END   = 3'd5
  } states_t;

  localparam logic [7:0] DEF_START_BYTE = 8'hAA;
  localparam logic [7:0] DEF_END_BYTE   = 8'hBB;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, wraps mod N, and
// moves the pointer past the winner whenever the grant is taken.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [PW-1:0] grant,
  output logic          any_req
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = PW'(idx);
      end
    end
  end

  assign any_req = |req;

  always_comb begin
    ptr_d = ptr_q;
    if (advance && any_req) begin
      ptr_d = (grant == PW'(N - 1)) ? '0 : grant + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/multi_channel_framer.sv
// Multi-channel UART framer: per-channel holding slots, round-robin pick, and
// serialisation of START, CH, payload (LSB first), CSUM, END with FIFO backpressure.
//
// state    | meaning
// IDLE     | waiting for a pending slot; grant loads shreg/chan/csum
// WR_START | presenting START_BYTE
// WR_CH    | presenting channel index
// WR_BYTES | presenting shreg[7:0], one payload byte per accepted write
// WR_CSUM  | presenting checksum
// WR_END   | presenting END_BYTE
module multi_channel_framer
  import framer_pkg::*;
#(
  parameter int         NBYTES     = 4,
  parameter int         NCH        = 2,
  parameter logic [7:0] START_BYTE = DEF_START_BYTE,
  parameter logic [7:0] END_BYTE   = DEF_END_BYTE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH*8*NBYTES-1:0] data_i,
  input  logic [NCH-1:0]          valid_i,
  output logic [NCH-1:0]          ready_o,
  input  logic                    uart_fifo_full_i,
  output logic [7:0]              uart_data_o,
  output logic                    uart_wr_en_o,
  output logic                    busy_o
);

  localparam int PLW = 8 * NBYTES;
  localparam int BCW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  states_t            state_q, state_d;
  logic [PLW-1:0]     slot_q [NCH];
  logic [PLW-1:0]     slot_d [NCH];
  logic [NCH-1:0]     pending_q, pending_d;
  logic [PLW-1:0]     shreg_q, shreg_d;
  logic [CW-1:0]      chan_q, chan_d;
  logic [7:0]         csum_q, csum_d;
  logic [BCW-1:0]     cnt_q, cnt_d;

  logic [NCH-1:0]     load;
  logic [CW-1:0]      grant;
  logic               any_req;
  logic               advance;

  assign ready_o = ~pending_q & {NCH{~rst}};
  assign load    = valid_i & ready_o;
  assign advance = (state_q == IDLE);

  rr_arbiter #(.N(NCH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (pending_q),
    .advance (advance),
    .grant   (grant),
    .any_req (any_req)
  );

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    pending_d = pending_q;
    shreg_d   = shreg_q;
    chan_d    = chan_q;
    csum_d    = csum_q;
    cnt_d     = cnt_q;

    for (int c = 0; c < NCH; c++) begin
      if (load[c]) begin
        slot_d[c]    = data_i[c*PLW +: PLW];
        pending_d[c] = 1'b1;
      end
    end

    // A granted slot is never loaded in the same cycle: pending keeps ready low.
    case (state_q)
      IDLE: begin
        if (any_req) begin
          shreg_d          = slot_q[grant];
          chan_d           = grant;
          csum_d           = 8'(grant);
          pending_d[grant] = 1'b0;
          state_d          = WR_START;
        end
      end
      WR_START: if (!uart_fifo_full_i) state_d = WR_CH;
      WR_CH:    if (!uart_fifo_full_i) state_d = WR_BYTES;
      WR_BYTES: begin
        if (!uart_fifo_full_i) begin
          shreg_d = shreg_q >> 8;
          csum_d  = csum_q + shreg_q[7:0];
          if (cnt_q == BCW'(NBYTES - 1)) begin
            cnt_d   = '0;
            state_d = WR_CSUM;
          end else begin
            cnt_d = cnt_q + BCW'(1);
          end
        end
      end
      WR_CSUM:  if (!uart_fifo_full_i) state_d = WR_END;
      WR_END:   if (!uart_fifo_full_i) state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      slot_q    <= '{default: '0};
      pending_q <= '0;
      shreg_q   <= '0;
      chan_q    <= '0;
      csum_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      pending_q <= pending_d;
      shreg_q   <= shreg_d;
      chan_q    <= chan_d;
      csum_q    <= csum_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    uart_data_o = shreg_q[7:0];
    case (state_q)
      WR_START: uart_data_o = START_BYTE;
      WR_CH:    uart_data_o = 8'(chan_q);
      WR_BYTES: uart_data_o = shreg_q[7:0];
      WR_CSUM:  uart_data_o = csum_q;
      WR_END:   uart_data_o = END_BYTE;
      default:  uart_data_o = shreg_q[7:0];
    endcase
  end

  assign uart_wr_en_o = (state_q != IDLE) && !uart_fifo_full_i;
  assign busy_o       = (state_q != IDLE);

endmodule
